window_convolver: RTL and testbench

WINDOW_CONVOLVER -- requirements
Module: window_convolver

---
 rtl/img_proc_pkg.sv | 27 ++
 rtl/window_convolver_if.sv | 20 ++
 rtl/conv_adder_tree.sv | 48 ++++
 rtl/window_convolver.sv | 71 +++++++
 tb/tb_window_convolver.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared widths, default image/kernel settings and tap arithmetic
package img_proc_pkg;
  localparam int PIXEL_W = 8;
  localparam int WINDOW_W = 72;
  localparam int COEF_W = 8;
  localparam int TAPS = 9;
  localparam int PROD_W = 17;
  localparam int SUM_W = 21;

  localparam int DEF_IMG_WIDTH = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam logic [WINDOW_W-1:0] DEF_KERNEL = 72'h01_02_01_02_04_02_01_02_01;
  localparam int DEF_SHIFT = 4;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // Both operands widened before the multiply so the product is never truncated.
  function automatic prod_t tap_product(input logic [PIXEL_W-1:0] pix, input coef_t c);
    prod_t p;
    prod_t q;
    p = prod_t'({1'b0, pix});
    q = prod_t'(c);
    return p * q;
  endfunction
endpackage

// File: rtl/window_convolver_if.sv
// rtl/window_convolver_if.sv - window-in / filtered-pixel-out signal bundle
interface window_convolver_if;
  import img_proc_pkg::*;

  logic                input_pixel_valid;
  logic [WINDOW_W-1:0] input_pixel_data;
  logic                output_pixel_valid;
  logic [PIXEL_W-1:0]  output_pixel_data;
  logic                output_intr;

  modport master (
    output input_pixel_valid, input_pixel_data,
    input  output_pixel_valid, output_pixel_data, output_intr
  );

  modport slave (
    input  input_pixel_valid, input_pixel_data,
    output output_pixel_valid, output_pixel_data, output_intr
  );
endinterface

// File: rtl/conv_adder_tree.sv
// rtl/conv_adder_tree.sv - stage 1 tap products and stage 2 signed sum of a 3x3 window
module conv_adder_tree
  import img_proc_pkg::*;
#(
  parameter logic [WINDOW_W-1:0] KERNEL = DEF_KERNEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                window_valid,
  input  logic [WINDOW_W-1:0] window,
  output logic                sum_valid,
  output sum_t                sum
);
  prod_t prod [TAPS];
  logic  prod_valid;
  sum_t  total;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_valid <= 1'b0;
      sum_valid  <= 1'b0;
    end else begin
      prod_valid <= window_valid;
      sum_valid  <= prod_valid;
    end
  end

  // Data stages only load on a valid slot; they need no reset.
  always_ff @(posedge clk) begin
    if (window_valid) begin
      for (int k = 0; k < TAPS; k++) begin
        prod[k] <= tap_product(window[k*PIXEL_W +: PIXEL_W],
                               coef_t'(KERNEL[k*COEF_W +: COEF_W]));
      end
    end
  end

  always_comb begin
    total = '0;
    for (int k = 0; k < TAPS; k++) begin
      total = total + sum_t'(prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (prod_valid) sum <= total;
  end
endmodule

// File: rtl/window_convolver.sv
// rtl/window_convolver.sv - 3-stage 3x3 convolver with frame counters and end-of-frame pulse
// Optional WINDOW_CONVOLVER_BORDER_ZERO_EN: zero outputs in the first two rows and columns.
module window_convolver
  import img_proc_pkg::*;
#(
  parameter int                  IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int                  IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter logic [WINDOW_W-1:0] KERNEL     = DEF_KERNEL,
  parameter int                  SHIFT      = DEF_SHIFT
) (
  input logic                clk,
  input logic                rst,
  window_convolver_if.slave  px
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic               sum_valid;
  sum_t               sum;
  sum_t               shifted;
  logic [PIXEL_W-1:0] pixel;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               last_col;
  logic               last_row;

  conv_adder_tree #(.KERNEL(KERNEL)) u_tree (
    .clk          (clk),
    .rst          (rst),
    .window_valid (px.input_pixel_valid),
    .window       (px.input_pixel_data),
    .sum_valid    (sum_valid),
    .sum          (sum)
  );

  assign last_col = (int'(col) == IMG_WIDTH - 1);
  assign last_row = (int'(row) == IMG_HEIGHT - 1);

  always_comb begin
    shifted = sum >>> SHIFT;
    if (shifted[SUM_W-1])              pixel = '0;
    else if (shifted > sum_t'(255))    pixel = '1;
    else                               pixel = shifted[PIXEL_W-1:0];
`ifdef WINDOW_CONVOLVER_BORDER_ZERO_EN
    if (int'(row) < 2 || int'(col) < 2) pixel = '0;
`endif
  end

  // col/row always name the position of the pixel currently in stage 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col                   <= '0;
      row                   <= '0;
      px.output_pixel_valid <= 1'b0;
      px.output_pixel_data  <= '0;
      px.output_intr        <= 1'b0;
    end else begin
      px.output_pixel_valid <= sum_valid;
      px.output_intr        <= sum_valid && last_col && last_row;
      if (sum_valid) begin
        px.output_pixel_data <= pixel;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_window_convolver.sv
// tb/tb_window_convolver.sv - directed checks of latency, clamping, framing, reset and border handling
module tb_window_convolver;
  import img_proc_pkg::*;

  localparam logic [WINDOW_W-1:0] LAP = 72'h00_FF_00_FF_04_FF_00_FF_00;
`ifdef WINDOW_CONVOLVER_BORDER_ZERO_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [7:0] sm_data[$];
  logic       sm_intr[$];
  int         stray_intr;

  window_convolver_if if_big();
  window_convolver_if if_lap();
  window_convolver_if if_small();

  window_convolver u_big (.clk(clk), .rst(rst), .px(if_big));

  window_convolver #(.KERNEL(LAP), .SHIFT(0)) u_lap (.clk(clk), .rst(rst), .px(if_lap));

  window_convolver #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (.clk(clk), .rst(rst), .px(if_small));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_small.output_pixel_valid) begin
      sm_data.push_back(if_small.output_pixel_data);
      sm_intr.push_back(if_small.output_intr);
    end else if (if_small.output_intr) begin
      stray_intr++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] small_exp(input int idx);
    int pos;
    pos = idx % 16;
    if (BORDER && (pos / 4 < 2 || pos % 4 < 2)) return 8'd0;
    return 8'd100;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    if_big.input_pixel_valid = 1'b0;   if_big.input_pixel_data = '0;
    if_lap.input_pixel_valid = 1'b0;   if_lap.input_pixel_data = '0;
    if_small.input_pixel_valid = 1'b0; if_small.input_pixel_data = '0;
    step(); step();
    total_cnt++; if (if_small.output_pixel_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_small.output_pixel_valid); else pass_cnt++;
    total_cnt++; if (if_small.output_pixel_data !== 8'd0) $display("FAIL reset_data got %0d want 0", if_small.output_pixel_data); else pass_cnt++;
    total_cnt++; if (if_small.output_intr !== 1'b0) $display("FAIL reset_intr got %b want 0", if_small.output_intr); else pass_cnt++;
    total_cnt++; if (if_big.output_pixel_valid !== 1'b0) $display("FAIL reset_big_valid got %b want 0", if_big.output_pixel_valid); else pass_cnt++;
    total_cnt++; if (if_lap.output_pixel_valid !== 1'b0) $display("FAIL reset_lap_valid got %b want 0", if_lap.output_pixel_valid); else pass_cnt++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_latency();
    logic [7:0] exp;
    exp = BORDER ? 8'd0 : 8'd100;
    if_big.input_pixel_data = {9{8'd100}};
    if_big.input_pixel_valid = 1'b1;
    step();
    if_big.input_pixel_valid = 1'b0;
    total_cnt++; if (if_big.output_pixel_valid !== 1'b0) $display("FAIL lat_c1 got %b want 0", if_big.output_pixel_valid); else pass_cnt++;
    step();
    total_cnt++; if (if_big.output_pixel_valid !== 1'b0) $display("FAIL lat_c2 got %b want 0", if_big.output_pixel_valid); else pass_cnt++;
    step();
    total_cnt++; if (if_big.output_pixel_valid !== 1'b1) $display("FAIL lat_c3_valid got %b want 1", if_big.output_pixel_valid); else pass_cnt++;
    total_cnt++; if (if_big.output_pixel_data !== exp) $display("FAIL lat_c3_data got %0d want %0d", if_big.output_pixel_data, exp); else pass_cnt++;
    step();
    total_cnt++; if (if_big.output_pixel_valid !== 1'b0) $display("FAIL lat_c4_valid got %b want 0", if_big.output_pixel_valid); else pass_cnt++;
    total_cnt++; if (if_big.output_pixel_data !== exp) $display("FAIL lat_hold_data got %0d want %0d", if_big.output_pixel_data, exp); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [71:0] win [3];
    logic [7:0]  exp [3];
    win[0] = {8'd128, 8'd112, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd16, 8'd0};
    win[1] = {9{8'd255}};
    win[2] = {9{8'd0}};
    exp[0] = BORDER ? 8'd0 : 8'd64;
    exp[1] = BORDER ? 8'd0 : 8'd255;
    exp[2] = 8'd0;
    for (int i = 0; i < 3; i++) begin
      if_big.input_pixel_data = win[i];
      if_big.input_pixel_valid = 1'b1;
      step();
    end
    if_big.input_pixel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (if_big.output_pixel_valid !== 1'b1 || if_big.output_pixel_data !== exp[i])
        $display("FAIL b2b_%0d got v=%b d=%0d want v=1 d=%0d", i, if_big.output_pixel_valid, if_big.output_pixel_data, exp[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++; if (if_big.output_pixel_valid !== 1'b0) $display("FAIL b2b_tail got %b want 0", if_big.output_pixel_valid); else pass_cnt++;
  endtask

  task automatic test_clamp();
    logic [71:0] win [3];
    logic [7:0]  exp [3];
    win[0] = 72'h00_00_00_00_FF_00_00_00_00;
    win[1] = 72'hFF_FF_FF_FF_00_FF_FF_FF_FF;
    win[2] = 72'h00_01_00_01_0A_01_00_01_00;
    exp[0] = BORDER ? 8'd0 : 8'd255;
    exp[1] = 8'd0;
    exp[2] = BORDER ? 8'd0 : 8'd36;
    for (int i = 0; i < 3; i++) begin
      if_lap.input_pixel_data = win[i];
      if_lap.input_pixel_valid = 1'b1;
      step();
      if_lap.input_pixel_valid = 1'b0;
      step(); step();
      total_cnt++;
      if (if_lap.output_pixel_valid !== 1'b1 || if_lap.output_pixel_data !== exp[i])
        $display("FAIL clamp_%0d got v=%b d=%0d want v=1 d=%0d", i, if_lap.output_pixel_valid, if_lap.output_pixel_data, exp[i]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_frame();
    sm_data.delete();
    sm_intr.delete();
    stray_intr = 0;
    if_small.input_pixel_data = {9{8'd100}};
    for (int i = 0; i < 32; i++) begin
      if_small.input_pixel_valid = 1'b1;
      step();
      if_small.input_pixel_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (4) step();
    total_cnt++; if (sm_data.size() !== 32) $display("FAIL frame_count got %0d want 32", sm_data.size()); else pass_cnt++;
    for (int i = 0; i < sm_data.size() && i < 32; i++) begin
      total_cnt++;
      if (sm_intr[i] !== (i == 15 || i == 31)) $display("FAIL frame_intr_%0d got %b want %b", i, sm_intr[i], (i == 15 || i == 31)); else pass_cnt++;
      total_cnt++;
      if (sm_data[i] !== small_exp(i)) $display("FAIL frame_data_%0d got %0d want %0d", i, sm_data[i], small_exp(i)); else pass_cnt++;
    end
    total_cnt++; if (stray_intr !== 0) $display("FAIL frame_stray_intr got %0d want 0", stray_intr); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    if_small.input_pixel_data = {9{8'd100}};
    if_small.input_pixel_valid = 1'b1;
    repeat (3) step();
    if_small.input_pixel_valid = 1'b0;
    repeat (4) step();
    if_small.input_pixel_valid = 1'b1;
    step(); step();
    if_small.input_pixel_valid = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt++; if (if_small.output_pixel_valid !== 1'b0) $display("FAIL async_valid got %b want 0", if_small.output_pixel_valid); else pass_cnt++;
    total_cnt++; if (if_small.output_pixel_data !== 8'd0) $display("FAIL async_data got %0d want 0", if_small.output_pixel_data); else pass_cnt++;
    total_cnt++; if (if_small.output_intr !== 1'b0) $display("FAIL async_intr got %b want 0", if_small.output_intr); else pass_cnt++;
    sm_data.delete();
    sm_intr.delete();
    step(); step();
    rst = 1'b1;
    repeat (5) step();
    total_cnt++; if (sm_data.size() !== 0) $display("FAIL stale_valid got %0d outputs want 0", sm_data.size()); else pass_cnt++;
    if_small.input_pixel_valid = 1'b1;
    repeat (16) step();
    if_small.input_pixel_valid = 1'b0;
    repeat (4) step();
    total_cnt++; if (sm_data.size() !== 16) $display("FAIL restart_count got %0d want 16", sm_data.size()); else pass_cnt++;
    for (int i = 0; i < sm_data.size() && i < 16; i++) begin
      total_cnt++;
      if (sm_intr[i] !== (i == 15) || sm_data[i] !== small_exp(i))
        $display("FAIL restart_%0d got i=%b d=%0d want i=%b d=%0d", i, sm_intr[i], sm_data[i], (i == 15), small_exp(i));
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    stray_intr = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_clamp();
    test_frame();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
